// File: rtl/datapath_mc_pkg.sv
// Shared definitions for the Mini-SRC datapath: ALU opcodes, bus source and
// load-enable bit positions, and the MUL/DIV sequencer state type.
package datapath_mc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_NEG  = 4'd9;
  localparam logic [3:0] ALU_NOT  = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;

  // Bit positions inside in_read_sel
  localparam int RS_REGFILE = 0;
  localparam int RS_HI      = 1;
  localparam int RS_LO      = 2;
  localparam int RS_ZHI     = 3;
  localparam int RS_ZLO     = 4;
  localparam int RS_PC      = 5;
  localparam int RS_MDR     = 6;
  localparam int RS_INPORT  = 7;
  localparam int RS_C       = 8;
  localparam int RS_W       = 9;

  // Bit positions inside in_write_en
  localparam int WE_REGFILE = 0;
  localparam int WE_HI      = 1;
  localparam int WE_LO      = 2;
  localparam int WE_Z       = 3;
  localparam int WE_PC      = 4;
  localparam int WE_MDR     = 5;
  localparam int WE_IR      = 6;
  localparam int WE_Y       = 7;
  localparam int WE_MAR     = 8;
  localparam int WE_OUTPORT = 9;
  localparam int WE_W       = 10;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_FIX  = 2'd2
  } seq_state_e;

  function automatic logic is_multi_hot(input logic [RS_W-1:0] v);
    return (v & (v - RS_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/mul_div_seq.sv
// Signed multi-cycle MUL/DIV: works on magnitudes for W iterations
// (shift-add multiply and restoring divide in parallel), then applies signs.
module mul_div_seq
  import datapath_mc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           is_div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output seq_state_e     state_o,
  output logic           done_o,
  output logic [2*W-1:0] result_o
);

  localparam int CW = $clog2(W);

  seq_state_e     state_q;
  logic [CW-1:0]  cnt_q;
  logic           is_div_q, neg_q, rneg_q, dz_q, done_q;
  logic [2*W-1:0] acc_q, mcand_q;
  logic [W-1:0]   mplier_q, quo_q, rem_q, dvsr_q;

  logic [W-1:0]   a_mag, b_mag, rem_diff, quo_res, rem_res;
  logic [W:0]     rem_sh;
  logic           rem_ge;

  assign a_mag    = a_i[W-1] ? -a_i : a_i;
  assign b_mag    = b_i[W-1] ? -b_i : b_i;
  assign rem_sh   = {rem_q, quo_q[W-1]};
  assign rem_ge   = rem_sh >= {1'b0, dvsr_q};
  assign rem_diff = rem_sh[W-1:0] - dvsr_q;

  // Division by zero keeps the natural remainder (= dividend) but forces the quotient to all ones
  assign quo_res  = dz_q ? '1 : (neg_q ? -quo_q : quo_q);
  assign rem_res  = rneg_q ? -rem_q : rem_q;
  assign result_o = is_div_q ? {rem_res, quo_res} : (neg_q ? -acc_q : acc_q);

  assign state_o  = state_q;
  assign done_o   = done_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q  <= SEQ_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SEQ_IDLE: begin
          if (start_i) begin
            state_q  <= SEQ_RUN;
            cnt_q    <= '0;
            is_div_q <= is_div_i;
            neg_q    <= a_i[W-1] ^ b_i[W-1];
            rneg_q   <= a_i[W-1];
            dz_q     <= (b_i == '0);
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a_mag};
            mplier_q <= b_mag;
            rem_q    <= '0;
            quo_q    <= a_mag;
            dvsr_q   <= b_mag;
          end
        end
        SEQ_RUN: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          rem_q    <= rem_ge ? rem_diff : rem_sh[W-1:0];
          quo_q    <= {quo_q[W-2:0], rem_ge};
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_q <= SEQ_FIX;
        end
        SEQ_FIX: begin
          state_q <= SEQ_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/datapath_mc.sv
// Mini-SRC datapath: single shared bus (one-hot source select), register file,
// special registers, single-cycle ALU and a multi-cycle MUL/DIV sequencer owning Z while busy.
module datapath_mc
  import datapath_mc_pkg::*;
#(
  parameter  int W       = 32,
  parameter  int NREGS   = 16,
  parameter  int C_BITS  = 19,
  parameter  int PC_STEP = 1,
  localparam int RSEL_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              in_clr,
  input  logic [RSEL_W-1:0] in_reg_sel,
  input  logic              in_BAout,
  input  logic [RS_W-1:0]   in_read_sel,
  input  logic [WE_W-1:0]   in_write_en,
  input  logic [3:0]        in_alu_op,
  input  logic              in_alu_start,
  input  logic              in_mdr_select,
  input  logic              in_inc_pc,
  input  logic [W-1:0]      in_mem_data,
  input  logic [W-1:0]      in_inport_data,
  output logic [W-1:0]      out_bus,
  output logic [W-1:0]      out_mar,
  output logic [W-1:0]      out_mdr,
  output logic [W-1:0]      out_ir,
  output logic [W-1:0]      out_outport,
  output logic              out_alu_busy,
  output logic              out_alu_done,
  output logic              out_bus_err
);

  localparam int SH_W = $clog2(W);

  logic [W-1:0]   rf_q [NREGS];
  logic [W-1:0]   hi_q, lo_q, y_q, pc_q, ir_q, mar_q, mdr_q, inport_q, outport_q;
  logic [2*W-1:0] z_q, z_d;
  logic [W-1:0]   pc_d, mdr_d;
  logic           bus_err_q, bus_err_d;

  logic [W-1:0]   bus, rf_rd, c_ext, alu_a, alu_b, alu_r;
  logic [SH_W-1:0] alu_sh;
  logic [2*W-1:0] alu_rot, alu_res, seq_res;
  logic           alu_sext, busy, md_start, seq_done;
  seq_state_e     seq_state;

  assign rf_rd = (in_BAout && in_reg_sel == '0) ? '0 : rf_q[in_reg_sel];
  assign c_ext = {{(W-C_BITS){ir_q[C_BITS-1]}}, ir_q[C_BITS-1:0]};

  // A multi-hot select drives 0 rather than an OR of sources
  always_comb begin
    bus = '0;
    if (!is_multi_hot(in_read_sel)) begin
      case (1'b1)
        in_read_sel[RS_REGFILE]: bus = rf_rd;
        in_read_sel[RS_HI]:      bus = hi_q;
        in_read_sel[RS_LO]:      bus = lo_q;
        in_read_sel[RS_ZHI]:     bus = z_q[2*W-1:W];
        in_read_sel[RS_ZLO]:     bus = z_q[W-1:0];
        in_read_sel[RS_PC]:      bus = pc_q;
        in_read_sel[RS_MDR]:     bus = mdr_q;
        in_read_sel[RS_INPORT]:  bus = inport_q;
        in_read_sel[RS_C]:       bus = c_ext;
        default:                 bus = '0;
      endcase
    end
  end

  always_comb begin
    alu_a    = y_q;
    alu_b    = bus;
    alu_sh   = alu_b[SH_W-1:0];
    alu_r    = '0;
    alu_rot  = {alu_a, alu_a};
    alu_sext = 1'b0;
    case (in_alu_op)
      ALU_ADD:  begin alu_r = alu_a + alu_b; alu_sext = 1'b1; end
      ALU_SUB:  begin alu_r = alu_a - alu_b; alu_sext = 1'b1; end
      ALU_NEG:  begin alu_r = -alu_b;        alu_sext = 1'b1; end
      ALU_AND:  alu_r = alu_a & alu_b;
      ALU_OR:   alu_r = alu_a | alu_b;
      ALU_SHR:  alu_r = alu_a >> alu_sh;
      ALU_SHRA: alu_r = $signed(alu_a) >>> alu_sh;
      ALU_SHL:  alu_r = alu_a << alu_sh;
      ALU_ROR:  begin alu_rot = {alu_a, alu_a} >> alu_sh; alu_r = alu_rot[W-1:0]; end
      ALU_ROL:  begin alu_rot = {alu_a, alu_a} << alu_sh; alu_r = alu_rot[2*W-1:W]; end
      ALU_NOT:  alu_r = ~alu_b;
      default:  alu_r = '0;
    endcase
    alu_res = alu_sext ? {{W{alu_r[W-1]}}, alu_r} : {{W{1'b0}}, alu_r};
  end

  assign busy     = (seq_state != SEQ_IDLE);
  assign md_start = in_alu_start && !busy &&
                    (in_alu_op == ALU_MUL || in_alu_op == ALU_DIV);

  mul_div_seq #(.W(W)) u_seq (
    .clk      (clk),
    .rst_i    (in_clr),
    .start_i  (md_start),
    .is_div_i (in_alu_op == ALU_DIV),
    .a_i      (y_q),
    .b_i      (bus),
    .state_o  (seq_state),
    .done_o   (seq_done),
    .result_o (seq_res)
  );

  always_comb begin
    pc_d      = in_inc_pc ? pc_q + W'(PC_STEP) : bus;
    mdr_d     = in_mdr_select ? in_mem_data : bus;
    bus_err_d = bus_err_q | is_multi_hot(in_read_sel);
    z_d       = z_q;
    if (seq_state == SEQ_FIX)             z_d = seq_res;
    else if (!busy && in_write_en[WE_Z])  z_d = alu_res;
  end

  always_ff @(posedge clk) begin
    if (in_clr) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      y_q       <= '0;
      z_q       <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      inport_q  <= in_inport_data;
      bus_err_q <= bus_err_d;
      z_q       <= z_d;
      if (in_write_en[WE_REGFILE]) rf_q[in_reg_sel] <= bus;
      if (in_write_en[WE_HI])      hi_q      <= bus;
      if (in_write_en[WE_LO])      lo_q      <= bus;
      if (in_write_en[WE_Y])       y_q       <= bus;
      if (in_write_en[WE_PC])      pc_q      <= pc_d;
      if (in_write_en[WE_IR])      ir_q      <= bus;
      if (in_write_en[WE_MAR])     mar_q     <= bus;
      if (in_write_en[WE_MDR])     mdr_q     <= mdr_d;
      if (in_write_en[WE_OUTPORT]) outport_q <= bus;
    end
  end

  assign out_bus      = bus;
  assign out_mar      = mar_q;
  assign out_mdr      = mdr_q;
  assign out_ir       = ir_q;
  assign out_outport  = outport_q;
  assign out_alu_busy = busy;
  assign out_alu_done = seq_done;
  assign out_bus_err  = bus_err_q;

endmodule
